// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch (if_*) and data (dm_*) requesters.
// Latency: accept -> mem_req_o next cycle; owner rvalid one cycle after mem_rvalid_i (3 cycles min).
// Backpressure: one transaction in flight; ready only in IDLE to one winner; watchdog ends stuck RESP.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: data beats fetch).
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_ready_o,
   output logic                    if_rvalid_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   input  logic                    dm_req_i,
   input  logic                    dm_we_i,
   input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
   input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] dm_be_i,
   output logic                    dm_ready_o,
   output logic                    dm_rvalid_o,
   output logic [DATA_WIDTH-1:0]   dm_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    timeout_o
);
   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_owner_dm;
   logic                   r_we;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [BE_WIDTH-1:0]    r_be;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_if_rvalid;
   logic                   r_dm_rvalid;
   logic                   r_timeout;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic                   w_prio_dm;
   logic                   w_grant_if;
   logic                   w_grant_dm;
   logic                   w_done;
   logic                   w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_dm;

   // Remember who was served last; reset state means fetch went last, so data wins the first tie.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                r_last_dm <= 1'b0;
      else if (w_grant_if || w_grant_dm) r_last_dm <= w_grant_dm;
   end

   assign w_prio_dm = ~r_last_dm;
`else
   assign w_prio_dm = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Arbitration, next state and completion detection; grants are suppressed while in reset.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_dm  = 1'b0;
      w_grant_if  = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_grant_dm = reset_n_i && dm_req_i && (!if_req_i || w_prio_dm);
            w_grant_if = reset_n_i && if_req_i && !w_grant_dm;
            if (w_grant_dm || w_grant_if) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (mem_gnt_i) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            // A real response beats a watchdog expiry in the same cycle.
            if (mem_rvalid_i) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
               w_done      = 1'b1;
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture the winner's request fields on accept and run the watchdog counter in RESP.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_owner_dm <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_grant_dm || w_grant_if) begin
            r_owner_dm <= w_grant_dm;
            r_we       <= w_grant_dm & dm_we_i;
            r_addr     <= w_grant_dm ? dm_addr_i  : if_addr_i;
            r_wdata    <= w_grant_dm ? dm_wdata_i : '0;
            r_be       <= w_grant_dm ? dm_be_i    : '1;
         end
         if (r_state == ST_REQ && mem_gnt_i) r_cnt <= '0;
         else if (r_state == ST_RESP)        r_cnt <= r_cnt + 1'b1;
      end
   end

   // Register the routed response; writes and timeouts return zero data.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_timeout   <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_if_rvalid <= w_done & ~r_owner_dm;
         r_dm_rvalid <= w_done & r_owner_dm;
         r_timeout   <= w_timeout;
         if (w_done) r_rdata <= (w_timeout || r_we) ? '0 : mem_rdata_i;
      end
   end

   assign if_ready_o  = w_grant_if;
   assign dm_ready_o  = w_grant_dm;
   assign if_rvalid_o = r_if_rvalid;
   assign dm_rvalid_o = r_dm_rvalid;
   assign if_rdata_o  = r_if_rvalid ? r_rdata : '0;
   assign dm_rdata_o  = r_dm_rvalid ? r_rdata : '0;
   assign timeout_o   = r_timeout;
   assign mem_req_o   = (r_state == ST_REQ);
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_be_o    = r_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          if_req_i, if_ready_o, if_rvalid_o;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i, dm_we_i, dm_ready_o, dm_rvalid_o;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i, dm_rdata_o;
   logic [BW-1:0] dm_be_i;
   logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, timeout_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;
   logic [BW-1:0] mem_be_o;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_be_i(dm_be_i), .dm_ready_o(dm_ready_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: pending requests, tie-break history, outstanding expected response.
   bit            m_last_dm;
   bit            g_hold;
   bit            p_if, p_dm, p_dm_we;
   logic [AW-1:0] p_if_addr, p_dm_addr;
   logic [DW-1:0] p_dm_wdata;
   logic [BW-1:0] p_dm_be;
   bit            e_if_rv, e_dm_rv, e_to;
   logic [DW-1:0] e_rdata;

   function automatic bit prio_dm();
`ifdef ARB_ROUND_ROBIN_EN
      return !m_last_dm;
`else
      return 1'b1;
`endif
   endfunction

   task automatic drive_reqs();
      if_req_i   = p_if;
      if_addr_i  = p_if_addr;
      dm_req_i   = p_dm;
      dm_we_i    = p_dm_we;
      dm_addr_i  = p_dm_addr;
      dm_wdata_i = p_dm_wdata;
      dm_be_i    = p_dm_be;
   endtask

   task automatic new_if(input logic [AW-1:0] a);
      p_if = 1'b1; p_if_addr = a;
   endtask

   task automatic new_dm(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      p_dm = 1'b1; p_dm_we = we; p_dm_addr = a; p_dm_wdata = d; p_dm_be = be;
   endtask

   // Compare the outputs expected in the cycle after a completion (or their absence).
   task automatic check_resp();
      chk("if_rvalid", if_rvalid_o, e_if_rv);
      chk("dm_rvalid", dm_rvalid_o, e_dm_rv);
      chk("timeout", timeout_o, e_to);
      chk("mem_req_idle", mem_req_o, 0);
      if (e_if_rv) chk("if_rdata", if_rdata_o, e_rdata);
      if (e_dm_rv) chk("dm_rdata", dm_rdata_o, e_rdata);
      e_if_rv = 0; e_dm_rv = 0; e_to = 0;
   endtask

   task automatic idle_cycle(input bit stale);
      @(negedge clk_i);
      drive_reqs();
      mem_gnt_i = 1'b0; mem_rvalid_i = stale; mem_rdata_i = $urandom;
      #1;
      check_resp();
      chk("if_ready_idle", if_ready_o, p_if && !(p_dm && prio_dm()));
      chk("dm_ready_idle", dm_ready_o, p_dm && (!p_if || prio_dm()));
   endtask

   // One complete transaction from the pending set; rsp_dly > TO means the memory never answers.
   task automatic do_txn(input int gnt_dly, input int rsp_dly, input logic [DW-1:0] rd,
                         input bit stale, input int abort_j, output bit obs_dm);
      bit            w_dm, x_we;
      logic [AW-1:0] x_addr;
      @(negedge clk_i);
      drive_reqs();
      mem_gnt_i = 1'b0; mem_rvalid_i = stale; mem_rdata_i = $urandom;
      #1;
      check_resp();
      w_dm = p_dm && (!p_if || prio_dm());
      obs_dm = dm_ready_o;
      chk("if_ready", if_ready_o, p_if && !w_dm);
      chk("dm_ready", dm_ready_o, w_dm);
      x_we   = w_dm ? p_dm_we : 1'b0;
      x_addr = w_dm ? p_dm_addr : p_if_addr;
      m_last_dm = w_dm;
      if (!g_hold) begin
         if (w_dm) p_dm = 1'b0; else p_if = 1'b0;
      end
      for (int k = 0; k <= gnt_dly; k++) begin
         @(negedge clk_i);
         drive_reqs();
         mem_gnt_i = (k == gnt_dly); mem_rvalid_i = stale & 1'($urandom_range(0, 1));
         mem_rdata_i = $urandom;
         #1;
         chk("mem_req", mem_req_o, 1);
         chk("mem_addr", mem_addr_o, x_addr);
         chk("mem_we", mem_we_o, x_we);
         if (w_dm) begin
            chk("mem_wdata", mem_wdata_o, p_dm_wdata);
            chk("mem_be", mem_be_o, p_dm_be);
         end
         chk("ready_req", {if_ready_o, dm_ready_o}, 0);
         chk("rvalid_req", {if_rvalid_o, dm_rvalid_o, timeout_o}, 0);
      end
      for (int j = 0; j <= TO; j++) begin
         @(negedge clk_i);
         drive_reqs();
         mem_gnt_i = 1'b0; mem_rvalid_i = (j == rsp_dly);
         mem_rdata_i = (j == rsp_dly) ? rd : $urandom;
         #1;
         chk("mem_req_resp", mem_req_o, 0);
         chk("ready_resp", {if_ready_o, dm_ready_o}, 0);
         chk("rvalid_resp", {if_rvalid_o, dm_rvalid_o, timeout_o}, 0);
         if (j == abort_j) begin
            #2 reset_n_i = 1'b0;
            #1;
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_out", {if_rvalid_o, dm_rvalid_o, timeout_o, if_ready_o, dm_ready_o}, 0);
            return;
         end
         if (j == rsp_dly || j == TO) begin
            e_to    = (j != rsp_dly);
            e_if_rv = !w_dm;
            e_dm_rv = w_dm;
            e_rdata = (e_to || x_we) ? '0 : rd;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      p_if = 0; p_dm = 0; m_last_dm = 0; g_hold = 0;
      e_if_rv = 0; e_dm_rv = 0; e_to = 0;
      drive_reqs();
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_outs", {if_ready_o, if_rvalid_o, dm_ready_o, dm_rvalid_o, mem_req_o, mem_we_o, timeout_o}, 0);
      chk("rst_fields", {mem_addr_o, mem_wdata_o}, 0);
      chk("rst_be", mem_be_o, 0);
      reset_n_i = 1'b1;
   endtask

   bit        obs;
   bit [3:0]  order;
   bit [3:0]  order_exp;

   initial begin
      p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0; p_dm_be = '0; p_dm_we = 0;
      apply_reset();

      // Directed: single fetch, single data write, grant delayed 3 cycles with a tie pending.
      new_if(32'h100);
      do_txn(0, 0, 32'hDEADBEEF, 0, -1, obs);
      new_dm(1'b1, 32'h2000, 32'h12345678, 4'hF);
      do_txn(0, 0, 32'hCAFEF00D, 0, -1, obs);
      new_if(32'h340); new_dm(1'b0, 32'h4400, 32'h0, 4'h3);
      do_txn(3, 1, 32'h0BADC0DE, 0, -1, obs);
      do_txn(3, 2, 32'h11112222, 0, -1, obs);

      // Directed: memory never answers, then a late rvalid while idle.
      new_if(32'h500);
      do_txn(0, 99, 32'h55555555, 0, -1, obs);
      idle_cycle(1);
      idle_cycle(0);

      // Directed: both requesters held high for four transactions.
      apply_reset();
      new_if(32'h600); new_dm(1'b0, 32'h7000, 32'h0, 4'hF);
      g_hold = 1;
      for (int t = 0; t < 4; t++) begin
         do_txn(0, 0, $urandom, 0, -1, obs);
         order[3-t] = obs;
      end
      g_hold = 0;
`ifdef ARB_ROUND_ROBIN_EN
      order_exp = 4'b1010;
`else
      order_exp = 4'b1111;
`endif
      chk("tie_order", order, order_exp);

      // Randomized traffic against the model.
      for (int it = 0; it < 60; it++) begin
         int gd, rdl;
         if (!p_if && !p_dm) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) new_if($urandom);
            if (!p_if || $urandom_range(0, 1) == 1)
               new_dm(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
         end else begin
            if (!p_if && $urandom_range(0, 1) == 1) new_if($urandom);
            if (!p_dm && $urandom_range(0, 1) == 1)
               new_dm(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
         end
         gd  = $urandom_range(0, 3);
         rdl = ($urandom_range(0, 4) == 0) ? TO + 1 + $urandom_range(0, 2) : $urandom_range(0, TO);
         do_txn(gd, rdl, $urandom, 1'($urandom_range(0, 1)), -1, obs);
      end
      idle_cycle(0);

      // Directed: reset during RESP, then a fresh fetch.
      p_if = 0; p_dm = 0;
      new_if(32'h800);
      do_txn(1, 99, 32'h0, 0, 2, obs);
      p_if = 0; p_dm = 0; m_last_dm = 0;
      e_if_rv = 0; e_dm_rv = 0; e_to = 0;
      drive_reqs();
      mem_rvalid_i = 1'b0;
      @(negedge clk_i);
      #1;
      chk("rst_hold", {mem_req_o, if_rvalid_o, dm_rvalid_o, timeout_o}, 0);
      reset_n_i = 1'b1;
      new_if(32'h900);
      do_txn(0, 1, 32'hA5A5A5A5, 0, -1, obs);
      idle_cycle(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port backing memory between the instruction-fetch path and the data-memory path of the pipelined core. Each requester accepts one transaction at a time with a request/ready handshake. The arbiter forwards the winning request to the memory, waits for the response, and routes it back to the owner. A watchdog ends any transaction the memory never answers, so the core cannot hang forever in system simulation.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in RESP before forced completion (≥1)

- clk_i  input  1  clock, all state on rising edge
- reset_n_i  input  1  reset, asynchronous, active-low
- if_req_i  input  1  fetch request; held with if_addr_i until if_ready_o
- if_addr_i  input  ADDR_WIDTH  fetch address
- if_ready_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch response valid, one-cycle pulse
- if_rdata_o  output  DATA_WIDTH  fetch data
- dm_req_i  input  1  data request; held with its fields until dm_ready_o
- dm_we_i  input  1  1 = write
- dm_addr_i  input  ADDR_WIDTH  data address
- dm_wdata_i  input  DATA_WIDTH  write data
- dm_be_i  input  DATA_WIDTH/8  byte enables
- dm_ready_o  output  1  data request accepted this cycle
- dm_rvalid_o  output  1  data response valid (read data or write ack), one-cycle pulse
- dm_rdata_o  output  DATA_WIDTH  read data; 0 for writes
- mem_req_o  output  1  memory request, held until mem_gnt_i
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  output  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered request fields
- mem_gnt_i  input  1  memory accepted request
- mem_rvalid_i  input  1  memory response; returned for reads and writes
- mem_rdata_i  input  DATA_WIDTH  memory read data
- timeout_o  output  1  one-cycle pulse when the watchdog forces completion

## Operation
- FSM states:
  - IDLE: arbitrate; on a grant, capture owner and fields, go to REQ.
  - REQ: mem_req_o = 1; on mem_gnt_i, clear the counter and go to RESP.
  - RESP: wait for mem_rvalid_i; then pulse the owner's rvalid_o and go to IDLE.
- if_ready_o and dm_ready_o are combinational. They are 1 only in IDLE, only for the winner, and never both at once.
- Priority: without the macro, data wins over fetch on a simultaneous request.
- Watchdog: 8-bit-or-wider counter, increments each cycle in RESP.
  - When the count reaches TIMEOUT_CYCLES with no mem_rvalid_i, the owner gets rvalid_o with rdata = 0, timeout_o pulses, and the FSM returns to IDLE.
- mem_rvalid_i arriving in IDLE or REQ (stale or late) is dropped; no rvalid_o is produced.
- Routing: rdata_o for the owner = mem_rdata_i for a read, 0 for a write. The non-owner's rvalid_o stays 0.
- Reset values: FSM IDLE; all outputs 0; captured fields 0; counter 0; round-robin pointer "fetch served last".
- Reset mid-transaction abandons it: no rvalid_o is produced, mem_req_o drops immediately (asynchronous).

## Timing
- Cycle A: request accepted (ready_o = 1).
- Cycle A+1: mem_req_o = 1, with fields registered from A.
- Grant at cycle G moves to RESP at G+1. The earliest mem_rvalid_i that counts is at G+1.
- mem_rvalid_i sampled at cycle R gives owner rvalid_o = 1 and rdata_o valid at R+1. The FSM is IDLE at R+1, where a new accept may occur.
- Minimum turnaround with zero-wait memory (gnt at A+1, rvalid at A+2): accept to rvalid_o = 3 cycles; back-to-back accepts every 3 cycles.
- Timeout: the last RESP cycle is the one where the count equals TIMEOUT_CYCLES. rvalid_o and timeout_o are high on the next cycle.
- mem_rvalid_i and the timeout in the same cycle: the real response wins, and timeout_o stays 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request, the requester not served last wins.
  - The pointer updates on every accept.
  - After reset, data wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority; the pointer logic is absent.

## Test plan
- Single fetch, address 0x100, memory gnt at +1, rvalid at +1 with 0xDEADBEEF → if_rvalid_o pulses at accept+3 with 0xDEADBEEF; dm_rvalid_o stays 0.
- Data write 0x2000/0x12345678/be 0xF → mem_we_o = 1 with the same fields; dm_rvalid_o pulse with dm_rdata_o = 0.
- Both requesters held high continuously for 4 transactions:
  - Macro off → order D,D,D,D.
  - Macro on → order D,F,D,F.
- Memory never asserts rvalid, TIMEOUT_CYCLES = 4 → owner rvalid_o with rdata 0 and timeout_o pulse 5 cycles after entering RESP. A late mem_rvalid_i in IDLE produces no output.
- reset_n_i low during RESP → outputs 0 asynchronously; after release, the FSM is IDLE and a fresh fetch completes normally.
- mem_gnt_i delayed 3 cycles → mem_req_o and its fields stay stable and unchanged until the grant; no second ready_o in the meantime.
